// File: rtl/zbus_pkg.sv
// Shared constants and FSM encoding for the CPLD breakout link master.
// Command codes, signal-byte bit positions and sequencer states.
package zbus_pkg;

  localparam logic [2:0] CMD_SIG = 3'b000;
  localparam logic [2:0] CMD_ALO = 3'b001;
  localparam logic [2:0] CMD_AHI = 3'b010;
  localparam logic [2:0] CMD_RDB = 3'b011;
  localparam logic [2:0] CMD_WRB = 3'b100;
  localparam logic [2:0] CMD_WRR = 3'b101;

  localparam int SIG_P1   = 7;
  localparam int SIG_P2   = 6;
  localparam int SIG_MREQ = 2;
  localparam int SIG_RD   = 1;
  localparam int SIG_M1   = 0;

  // RD is active-low on the wire, so the idle signal byte has RD=1 (no read).
  localparam logic [7:0] SIG_RESET = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SIG,
    ST_ALO,
    ST_AHI,
    ST_DAT,
    ST_CHECK,
    ST_OFFER,
    ST_WAIT_RSP,
    ST_WRB,
    ST_WAIT_END,
    ST_REG
  } state_e;

endpackage

// File: rtl/zbus_act_sync.sv
// Brings the asynchronous active-low ACT strobe into the CLK domain and
// derives single-cycle falling/rising edge pulses from the synchronised level.
module zbus_act_sync (
  input  logic clk,
  input  logic rst,
  input  logic act_n,
  output logic act_s,
  output logic act_fall,
  output logic act_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = act_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // All stages reset high so a reset never looks like a bus cycle start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign act_s    = sync_q;
  assign act_fall = prev_q & ~sync_q;
  assign act_rise = ~prev_q & sync_q;

endmodule

// File: rtl/zbus_sequencer.sv
// FPGA-side master of the CPLD breakout link: reads each Z80 cycle through the
// CPLD, checks parity, hands it downstream, and writes read data / host registers back.
module zbus_sequencer
  import zbus_pkg::*;
#(
  parameter int SETTLE    = 3,
  parameter int HOLD      = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ACT,
  output logic [2:0]  CMD,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        txn_valid,
  input  logic        txn_ready,
  output logic [15:0] txn_addr,
  output logic [7:0]  txn_data,
  output logic        txn_rd,
  output logic        txn_io,
  output logic        txn_m1,
  output logic        txn_err,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        reg_wr_valid,
  input  logic [7:0]  reg_wr_data,
  output logic        reg_wr_ready,
  output logic [7:0]  abort_cnt
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  sig_q, sig_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  out_q, out_d;
  logic [7:0]  abort_q, abort_d;
  logic        pend_q, pend_d;

  logic act_s, act_fall, act_rise;
  logic start, settle_last, hold_last;
  logic p1_exp, mismatch, abortable;
  logic sig_unused;

  zbus_act_sync u_act_sync (
    .clk      (CLK),
    .rst      (RESET),
    .act_n    (ACT),
    .act_s    (act_s),
    .act_fall (act_fall),
    .act_rise (act_rise)
  );

  // A fall seen while busy with a register write is remembered until IDLE.
  assign start       = act_fall | pend_q;
  assign settle_last = (cnt_q == 4'(SETTLE - 1));
  assign hold_last   = (cnt_q == 4'(HOLD - 1));
  assign p1_exp      = ^addr_q ^ ~sig_q[SIG_MREQ] ^ sig_q[SIG_MREQ] ^ sig_q[SIG_RD] ^ sig_q[SIG_M1];
  assign mismatch    = (sig_q[SIG_P1] != p1_exp) | (sig_q[SIG_RD] & (sig_q[SIG_P2] != ^data_q));
  assign abortable   = state_q inside {ST_SIG, ST_ALO, ST_AHI, ST_DAT, ST_CHECK, ST_OFFER, ST_WAIT_RSP};
  assign sig_unused  = ^sig_q[5:3];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      sig_q   <= SIG_RESET;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
      abort_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sig_q   <= sig_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      out_q   <= out_d;
      abort_q <= abort_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    sig_d   = sig_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    out_d   = out_q;
    abort_d = abort_q;
    pend_d  = pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SIG;
          retry_d = '0;
        end else if (reg_wr_valid) begin
          state_d = ST_REG;
          out_d   = reg_wr_data;
        end
      end
      ST_SIG: if (settle_last) begin
        sig_d   = D_IN;
        state_d = ST_ALO;
      end
      ST_ALO: if (settle_last) begin
        addr_d[7:0] = D_IN;
        state_d     = ST_AHI;
      end
      ST_AHI: if (settle_last) begin
        addr_d[15:8] = D_IN;
        if (sig_q[SIG_RD]) begin
          state_d = ST_DAT;
        end else begin
          data_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_DAT: if (settle_last) begin
        data_d  = D_IN;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch && (retry_q < 4'(MAX_RETRY))) begin
          retry_d = retry_q + 4'd1;
          state_d = ST_SIG;
        end else begin
          err_d   = mismatch;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: if (txn_ready) state_d = sig_q[SIG_RD] ? ST_WAIT_END : ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_valid) begin
        out_d   = rsp_data;
        state_d = ST_WRB;
      end
      ST_WRB:      if (hold_last) state_d = ST_WAIT_END;
      ST_WAIT_END: if (act_s) state_d = ST_IDLE;
      ST_REG:      if (hold_last) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (abortable && act_s) begin
      state_d = ST_IDLE;
      if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
    end

    if (act_rise) pend_d = 1'b0;
    else if (act_fall && (state_q != ST_IDLE)) pend_d = 1'b1;
    else if (state_q == ST_IDLE) pend_d = 1'b0;

    cnt_d = (state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
  end

  always_comb begin
    CMD          = CMD_SIG;
    D_OUT        = '0;
    txn_valid    = 1'b0;
    reg_wr_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  reg_wr_ready = ~start & reg_wr_valid;
      ST_ALO:   CMD = CMD_ALO;
      ST_AHI:   CMD = CMD_AHI;
      ST_DAT:   CMD = CMD_RDB;
      ST_OFFER: txn_valid = 1'b1;
      ST_WRB: begin
        CMD   = CMD_WRB;
        D_OUT = out_q;
      end
      ST_REG: begin
        CMD   = CMD_WRR;
        D_OUT = out_q;
      end
      default: CMD = CMD_SIG;
    endcase
  end

  assign D_OE      = CMD[2];
  assign txn_addr  = addr_q;
  assign txn_data  = data_q;
  assign txn_rd    = ~sig_q[SIG_RD];
  assign txn_io    = sig_q[SIG_MREQ];
  assign txn_m1    = sig_q[SIG_M1];
  assign txn_err   = err_q;
  assign abort_cnt = abort_q;

endmodule

// File: tb/tb_zbus_sequencer.sv
// Directed bench for zbus_sequencer: a small CPLD responder answers CMD reads,
// and each scenario task checks its own hand-computed expectations.
module tb_zbus_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ACT = 1'b1;
  logic [2:0]  CMD;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        txn_valid;
  logic        txn_ready = 1'b0;
  logic [15:0] txn_addr;
  logic [7:0]  txn_data;
  logic        txn_rd, txn_io, txn_m1, txn_err;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        reg_wr_valid = 1'b0;
  logic [7:0]  reg_wr_data = 8'h00;
  logic        reg_wr_ready;
  logic [7:0]  abort_cnt;

  zbus_sequencer dut (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .CMD(CMD), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr), .txn_data(txn_data),
    .txn_rd(txn_rd), .txn_io(txn_io), .txn_m1(txn_m1), .txn_err(txn_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .reg_wr_valid(reg_wr_valid),
    .reg_wr_data(reg_wr_data), .reg_wr_ready(reg_wr_ready), .abort_cnt(abort_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_data = 8'h00;
  logic [7:0]  sig_byte = 8'h02;
  int          bad_count = 0;
  int          ahi_base = 0;
  logic [7:0]  exp_out = 8'h00;

  int ahi_done = 0, wrb_cyc = 0, wrb_good = 0, reg_cyc = 0, reg_good = 0, rdy_cyc = 0, oe_viol = 0;
  logic [2:0] last_cmd = 3'b000;
  logic [2:0] cmd_log[$];

  // CPLD model: answers each read command; p1 is corrupted for the first bad_count attempts.
  always @* begin
    case (CMD)
      3'b000:  D_IN = ((ahi_done - ahi_base) < bad_count) ? (sig_byte ^ 8'h80) : sig_byte;
      3'b001:  D_IN = m_addr[7:0];
      3'b010:  D_IN = m_addr[15:8];
      3'b011:  D_IN = m_data;
      default: D_IN = 8'h00;
    endcase
  end

  always @(negedge CLK) begin
    if (CMD != last_cmd) begin
      cmd_log.push_back(CMD);
      if (last_cmd == 3'b010) ahi_done++;
    end
    last_cmd = CMD;
    if (D_OE !== CMD[2]) oe_viol++;
    if (CMD == 3'b100) begin
      wrb_cyc++;
      if (D_OE && D_OUT == exp_out) wrb_good++;
    end
    if (CMD == 3'b101) begin
      reg_cyc++;
      if (D_OE && D_OUT == exp_out) reg_good++;
    end
    if (reg_wr_ready) rdy_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!txn_valid && cycles < limit) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    ACT = 1'b1;
    tick(3);
    n_cmp++; if (CMD !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_cmd: got %b want 000", CMD); end
    n_cmp++; if ({D_OE, D_OUT} !== 9'h000) begin n_bad++; $display("[TB] FAIL reset_dout: got oe=%b d=%h want 0/00", D_OE, D_OUT); end
    n_cmp++; if ({txn_valid, reg_wr_ready} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_handshakes: got %b want 00", {txn_valid, reg_wr_ready}); end
    n_cmp++; if ({txn_addr, txn_data, txn_rd, txn_io, txn_m1, txn_err} !== 28'h0) begin n_bad++;
      $display("[TB] FAIL reset_txn_fields: got %h want 0", {txn_addr, txn_data, txn_rd, txn_io, txn_m1, txn_err}); end
    n_cmp++; if (abort_cnt !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_abort_cnt: got %h want 00", abort_cnt); end
    RESET = 1'b0;
    tick(2);
  endtask

  task automatic test_mem_write;
    int lat, log_base, wrb0;
    logic [11:0] seq;
    log_base = cmd_log.size();
    wrb0 = wrb_cyc;
    m_addr = 16'h4000; m_data = 8'hA5; sig_byte = 8'h82; bad_count = 0; ahi_base = ahi_done;
    txn_ready = 1'b1;
    ACT = 1'b0;
    wait_valid(40, lat);
    n_cmp++; if (txn_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_valid: got %b want 1", txn_valid); end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("[TB] FAIL wr_latency: got %0d want 16", lat); end
    n_cmp++; if ({txn_addr, txn_data} !== 24'h4000A5) begin n_bad++; $display("[TB] FAIL wr_addr_data: got %h want 4000a5", {txn_addr, txn_data}); end
    n_cmp++; if ({txn_rd, txn_io, txn_m1, txn_err} !== 4'b0000) begin n_bad++;
      $display("[TB] FAIL wr_flags: got rd/io/m1/err=%b want 0000", {txn_rd, txn_io, txn_m1, txn_err}); end
    tick(4);
    n_cmp++; if ({txn_valid, CMD} !== 4'b0000) begin n_bad++; $display("[TB] FAIL wr_wait_end: got valid/cmd=%b want 0000", {txn_valid, CMD}); end
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      seq = seq << 3;
      seq[2:0] = (cmd_log.size() > log_base + i) ? cmd_log[log_base + i] : 3'b111;
    end
    n_cmp++; if (seq !== {3'b001, 3'b010, 3'b011, 3'b000}) begin n_bad++; $display("[TB] FAIL wr_cmd_seq: got %o want 1230 (octal)", seq); end
    n_cmp++; if (wrb_cyc - wrb0 !== 0) begin n_bad++; $display("[TB] FAIL wr_no_wrb: got %0d write-bus cycles want 0", wrb_cyc - wrb0); end
    ACT = 1'b1;
    tick(4);
    n_cmp++; if (abort_cnt !== 8'h00) begin n_bad++; $display("[TB] FAIL wr_abort_cnt: got %h want 00", abort_cnt); end
  endtask

  task automatic test_io_read;
    int lat, wrb0, good0;
    m_addr = 16'h0098; m_data = 8'h77; sig_byte = 8'h85; bad_count = 0; ahi_base = ahi_done;
    exp_out = 8'h3C;
    wrb0 = wrb_cyc; good0 = wrb_good;
    txn_ready = 1'b1;
    ACT = 1'b0;
    wait_valid(40, lat);
    n_cmp++; if (lat !== 13) begin n_bad++; $display("[TB] FAIL rd_latency: got %0d want 13", lat); end
    n_cmp++; if ({txn_addr, txn_data} !== 24'h009800) begin n_bad++; $display("[TB] FAIL rd_addr_data: got %h want 009800", {txn_addr, txn_data}); end
    n_cmp++; if ({txn_rd, txn_io, txn_m1, txn_err} !== 4'b1110) begin n_bad++;
      $display("[TB] FAIL rd_flags: got rd/io/m1/err=%b want 1110", {txn_rd, txn_io, txn_m1, txn_err}); end
    tick(5);
    rsp_valid = 1'b1; rsp_data = 8'h3C;
    tick(1);
    rsp_valid = 1'b0; rsp_data = 8'h00;
    tick(7);
    n_cmp++; if (wrb_cyc - wrb0 !== 4) begin n_bad++; $display("[TB] FAIL rd_wrb_cycles: got %0d want 4", wrb_cyc - wrb0); end
    n_cmp++; if (wrb_good - good0 !== 4) begin n_bad++; $display("[TB] FAIL rd_wrb_data: got %0d good cycles want 4", wrb_good - good0); end
    tick(3);
    n_cmp++; if ({D_OE, CMD} !== 4'b0000) begin n_bad++; $display("[TB] FAIL rd_wait_end: got oe/cmd=%b want 0000", {D_OE, CMD}); end
    ACT = 1'b1;
    tick(4);
  endtask

  task automatic test_parity_retry;
    int lat;
    m_addr = 16'h4000; m_data = 8'hA5; sig_byte = 8'h82;
    txn_ready = 1'b1;
    ahi_base = ahi_done; bad_count = 1;
    ACT = 1'b0;
    wait_valid(80, lat);
    n_cmp++; if (lat !== 29) begin n_bad++; $display("[TB] FAIL retry1_latency: got %0d want 29", lat); end
    n_cmp++; if ({txn_valid, txn_err} !== 2'b10) begin n_bad++; $display("[TB] FAIL retry1_err: got valid/err=%b want 10", {txn_valid, txn_err}); end
    n_cmp++; if (ahi_done - ahi_base !== 2) begin n_bad++; $display("[TB] FAIL retry1_reads: got %0d address passes want 2", ahi_done - ahi_base); end
    tick(1);
    ACT = 1'b1;
    tick(4);
    ahi_base = ahi_done; bad_count = 3;
    ACT = 1'b0;
    wait_valid(100, lat);
    n_cmp++; if (lat !== 42) begin n_bad++; $display("[TB] FAIL retry3_latency: got %0d want 42", lat); end
    n_cmp++; if ({txn_valid, txn_err, txn_addr} !== {2'b11, 16'h4000}) begin n_bad++;
      $display("[TB] FAIL retry3_err: got valid/err/addr=%b/%h want 11/4000", {txn_valid, txn_err}, txn_addr); end
    n_cmp++; if (ahi_done - ahi_base !== 3) begin n_bad++; $display("[TB] FAIL retry3_reads: got %0d address passes want 3", ahi_done - ahi_base); end
    tick(1);
    ACT = 1'b1;
    tick(4);
    bad_count = 0;
  endtask

  task automatic test_abort_wait_rsp;
    int lat, wrb0;
    m_addr = 16'h0098; sig_byte = 8'h85; bad_count = 0; ahi_base = ahi_done;
    wrb0 = wrb_cyc;
    txn_ready = 1'b1;
    n_cmp++; if (abort_cnt !== 8'h00) begin n_bad++; $display("[TB] FAIL abort_before: got %h want 00", abort_cnt); end
    ACT = 1'b0;
    wait_valid(40, lat);
    tick(3);
    ACT = 1'b1;
    tick(5);
    n_cmp++; if (abort_cnt !== 8'h01) begin n_bad++; $display("[TB] FAIL abort_count: got %h want 01", abort_cnt); end
    n_cmp++; if (wrb_cyc - wrb0 !== 0) begin n_bad++; $display("[TB] FAIL abort_no_wrb: got %0d write-bus cycles want 0", wrb_cyc - wrb0); end
    n_cmp++; if ({txn_valid, CMD} !== 4'b0000) begin n_bad++; $display("[TB] FAIL abort_idle: got valid/cmd=%b want 0000", {txn_valid, CMD}); end
  endtask

  task automatic test_reg_write;
    int reg0, good0, rdy0;
    reg0 = reg_cyc; good0 = reg_good; rdy0 = rdy_cyc;
    exp_out = 8'h15;
    reg_wr_data = 8'h15; reg_wr_valid = 1'b1;
    #1;
    n_cmp++; if (reg_wr_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reg_ready_idle: got %b want 1", reg_wr_ready); end
    tick(1);
    reg_wr_valid = 1'b0; reg_wr_data = 8'h00;
    n_cmp++; if ({reg_wr_ready, D_OE, CMD, D_OUT} !== {2'b01, 3'b101, 8'h15}) begin n_bad++;
      $display("[TB] FAIL reg_first_cycle: got rdy=%b oe=%b cmd=%b d=%h want 0/1/101/15", reg_wr_ready, D_OE, CMD, D_OUT); end
    tick(6);
    n_cmp++; if (reg_cyc - reg0 !== 4) begin n_bad++; $display("[TB] FAIL reg_cycles: got %0d want 4", reg_cyc - reg0); end
    n_cmp++; if (reg_good - good0 !== 4) begin n_bad++; $display("[TB] FAIL reg_data: got %0d good cycles want 4", reg_good - good0); end
    n_cmp++; if (rdy_cyc - rdy0 !== 1) begin n_bad++; $display("[TB] FAIL reg_ready_pulse: got %0d ready cycles want 1", rdy_cyc - rdy0); end
  endtask

  task automatic test_back_to_back;
    int lat, rdy0, reg0, good0, waited;
    bit found;
    m_addr = 16'h4000; m_data = 8'hA5; sig_byte = 8'h82; bad_count = 0; ahi_base = ahi_done;
    txn_ready = 1'b1;
    exp_out = 8'h2A;
    rdy0 = rdy_cyc; reg0 = reg_cyc; good0 = reg_good;
    ACT = 1'b0;
    tick(2);
    reg_wr_data = 8'h2A; reg_wr_valid = 1'b1;
    #1;
    n_cmp++; if (reg_wr_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_start_wins: got ready=%b want 0", reg_wr_ready); end
    wait_valid(40, lat);
    n_cmp++; if (lat !== 14) begin n_bad++; $display("[TB] FAIL b2b_latency: got %0d want 14", lat); end
    tick(1);
    n_cmp++; if (rdy_cyc - rdy0 !== 0) begin n_bad++; $display("[TB] FAIL b2b_reg_waits: got %0d ready cycles want 0", rdy_cyc - rdy0); end
    ACT = 1'b1;
    found = 1'b0; waited = 0;
    while (!found && waited < 20) begin
      tick(1);
      waited++;
      found = reg_wr_ready;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_reg_taken: got %b want 1", found); end
    tick(1);
    reg_wr_valid = 1'b0; reg_wr_data = 8'h00;
    tick(6);
    n_cmp++; if ({reg_cyc - reg0, reg_good - good0} !== {32'd4, 32'd4}) begin n_bad++;
      $display("[TB] FAIL b2b_reg_write: got %0d cycles %0d good want 4 4", reg_cyc - reg0, reg_good - good0); end
  endtask

  task automatic test_reset_mid_offer;
    int lat;
    m_addr = 16'h4000; m_data = 8'hA5; sig_byte = 8'h82; bad_count = 0; ahi_base = ahi_done;
    txn_ready = 1'b0;
    ACT = 1'b0;
    wait_valid(40, lat);
    tick(3);
    n_cmp++; if ({txn_valid, txn_addr} !== {1'b1, 16'h4000}) begin n_bad++;
      $display("[TB] FAIL offer_stable: got valid=%b addr=%h want 1/4000", txn_valid, txn_addr); end
    #1;
    RESET = 1'b1;
    #1;
    n_cmp++; if ({txn_valid, D_OE, CMD} !== 5'b00000) begin n_bad++;
      $display("[TB] FAIL async_reset_outputs: got valid/oe/cmd=%b want 00000", {txn_valid, D_OE, CMD}); end
    n_cmp++; if ({txn_addr, abort_cnt} !== 24'h000000) begin n_bad++;
      $display("[TB] FAIL async_reset_regs: got addr=%h abort=%h want 0000/00", txn_addr, abort_cnt); end
    ACT = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_io_read();
    test_parity_retry();
    test_abort_wait_rsp();
    test_reg_write();
    test_back_to_back();
    test_reset_mid_offer();
    n_cmp++; if (oe_viol !== 0) begin n_bad++; $display("[TB] FAIL oe_tracks_cmd2: got %0d bad cycles want 0", oe_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
